// File: rtl/mem_req_initiator_if.sv
// Valid/ready request channel plus response channel between the MEM-stage
// requester and a memory or NoC responder.
interface mem_req_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_req_initiator.sv
// MEM-stage data-memory requester: issues one load/store at a time over a
// valid/ready port, stalls the pipeline until the response or a timeout.
module mem_req_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Mem_Read_M,
  input  logic              Mem_Write_M,
  input  logic [31:0]       ALU_result_M,
  input  logic [DATA_W-1:0] Write_Data_M,
  output logic              stall_M,
  output logic [DATA_W-1:0] mem_read_M,
  output logic              access_err_M,
  mem_req_initiator_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic             op, aligned, issue, reject;
  logic [CNT_W-1:0] cnt_inc;

  assign op      = Mem_Read_M | Mem_Write_M;
  assign aligned = (ALU_result_M[1:0] == 2'b00);
  assign issue   = op & aligned & ~(Mem_Read_M & Mem_Write_M);
  assign reject  = op & ~issue;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          write_d = Mem_Write_M;
          addr_d  = ALU_result_M[ADDR_W-1:0];
          wdata_d = Write_Data_M;
          state_d = S_REQ;
        end else if (reject) begin
          err_d = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.req_ready) begin
          cnt_d = '0;
          if (bus.resp_valid) begin
            rdata_d = write_q ? '0 : bus.resp_rdata;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // A response arriving in the last allowed cycle still beats the timeout.
        if (bus.resp_valid) begin
          rdata_d = write_q ? '0 : bus.resp_rdata;
          state_d = S_DONE;
        end else if (cnt_inc == TIMEOUT_C) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rdata_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by reset so every output reads 0 while reset is held.
  assign stall_M = rst & (((state_q == S_IDLE) & issue) |
                          (state_q == S_REQ) | (state_q == S_WAIT));

  assign mem_read_M    = rdata_q;
  assign access_err_M  = err_q;
  assign bus.req_valid = (state_q == S_REQ);
  assign bus.req_write = write_q;
  assign bus.req_addr  = addr_q;
  assign bus.req_wdata = wdata_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed and randomized transactions against a transaction-level model of
// the requester: stall length, request-phase length, load data and error pulse.
module tb_mem_req_initiator;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_Read_M, Mem_Write_M;
  logic [31:0] ALU_result_M, Write_Data_M;
  logic        stall_M, access_err_M;
  logic [31:0] mem_read_M;

  int n_checks = 0;
  int n_fails  = 0;

  mem_req_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_req_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .Mem_Read_M   (Mem_Read_M),
    .Mem_Write_M  (Mem_Write_M),
    .ALU_result_M (ALU_result_M),
    .Write_Data_M (Write_Data_M),
    .stall_M      (stall_M),
    .mem_read_M   (mem_read_M),
    .access_err_M (access_err_M),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"},     64'(stall_M),          64'd0);
    check({tag, ".req_valid"}, 64'(bus_if.req_valid), 64'd0);
    check({tag, ".req_write"}, 64'(bus_if.req_write), 64'd0);
    check({tag, ".req_addr"},  64'(bus_if.req_addr),  64'd0);
    check({tag, ".req_wdata"}, 64'(bus_if.req_wdata), 64'd0);
    check({tag, ".mem_read"},  64'(mem_read_M),       64'd0);
    check({tag, ".err"},       64'(access_err_M),     64'd0);
  endtask

  // sdly: 0 = response together with acceptance, k = response in k-th cycle after acceptance.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int rdly, input int sdly, input logic [31:0] rdata);
    logic good, timed_out, is_op;
    int waitc, exp_e, window;
    int st_cnt, rv_cnt, bad_fields, err_cnt, err_idx, stray_data, rv_seen, widx;
    logic accepted;
    logic [31:0] done_data, exp_data;

    is_op     = rd | wr;
    good      = is_op && (addr[1:0] == 2'b00) && !(rd && wr);
    waitc     = (sdly == 0) ? 0 : ((sdly < TO) ? sdly : TO);
    timed_out = good && (sdly > TO);
    exp_e     = good ? (2 + rdly + waitc) : -1;
    window    = good ? (exp_e + 1) : 2;
    exp_data  = (good && rd && !timed_out) ? rdata : 32'd0;

    st_cnt = 0; rv_cnt = 0; bad_fields = 0; err_cnt = 0; err_idx = -1;
    stray_data = 0; rv_seen = 0; widx = 0; accepted = 1'b0; done_data = 32'd0;

    for (int c = 0; c < window; c++) begin
      @(negedge clk);
      Mem_Read_M   = (c == 0) ? rd : (c == exp_e);
      Mem_Write_M  = (c == 0) ? wr : 1'b0;
      ALU_result_M = (c == 0) ? addr : ($urandom & 32'hFFFF_FFFC);
      Write_Data_M = (c == 0) ? wdata : $urandom;
      bus_if.req_ready  = 1'b0;
      bus_if.resp_valid = 1'b0;
      bus_if.resp_rdata = $urandom;
      #1;
      if (accepted) begin
        widx++;
        if (sdly > 0 && widx == sdly) begin
          bus_if.resp_valid = 1'b1;
          bus_if.resp_rdata = rdata;
        end
      end else if (bus_if.req_valid) begin
        if (rv_seen == rdly) begin
          bus_if.req_ready = 1'b1;
          accepted = 1'b1;
          if (sdly == 0) begin
            bus_if.resp_valid = 1'b1;
            bus_if.resp_rdata = rdata;
          end
        end else begin
          bus_if.resp_valid = 1'($urandom_range(0, 1));
        end
        rv_seen++;
      end
      #1;
      if (stall_M) st_cnt++;
      if (bus_if.req_valid) begin
        rv_cnt++;
        if (bus_if.req_addr !== addr || bus_if.req_wdata !== wdata || bus_if.req_write !== wr)
          bad_fields++;
      end
      if (access_err_M) begin
        err_cnt++;
        err_idx = c;
      end
      if (c == exp_e) done_data = mem_read_M;
      else if (mem_read_M !== 32'd0) stray_data++;
    end

    check({tag, ".stall_cycles"}, 64'(st_cnt), 64'(good ? exp_e : 0));
    check({tag, ".req_cycles"},   64'(rv_cnt), 64'(good ? rdly + 1 : 0));
    check({tag, ".req_stable"},   64'(bad_fields), 64'd0);
    check({tag, ".err_pulses"},   64'(err_cnt), 64'((timed_out || (is_op && !good)) ? 1 : 0));
    check({tag, ".err_cycle"},    64'(err_idx), 64'(timed_out ? exp_e : ((is_op && !good) ? 1 : -1)));
    if (good) check({tag, ".done_data"}, 64'(done_data), 64'(exp_data));
    check({tag, ".stray_data"},   64'(stray_data), 64'd0);
    $display("txn %s rd=%0b wr=%0b addr=0x%08h rdly=%0d sdly=%0d stall=%0d data=0x%08h err=%0d",
             tag, rd, wr, addr, rdly, sdly, st_cnt, done_data, err_cnt);
  endtask

  initial begin
    rst = 1'b0;
    Mem_Read_M = 1'b0; Mem_Write_M = 1'b0;
    ALU_result_M = 32'd0; Write_Data_M = 32'd0;
    bus_if.req_ready = 1'b0; bus_if.resp_valid = 1'b0; bus_if.resp_rdata = 32'd0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    run_access("load8",      1'b1, 1'b0, 32'h8,  32'h0,        0, 1,  32'hDEADBEEF);
    run_access("store4",     1'b0, 1'b1, 32'h4,  32'h12345678, 4, 1,  32'hCAFEF00D);
    run_access("misaligned", 1'b1, 1'b0, 32'h6,  32'h0,        0, 1,  32'h11111111);
    run_access("timeout",    1'b1, 1'b0, 32'h20, 32'h0,        0, 99, 32'h22222222);
    run_access("same_cycle", 1'b1, 1'b0, 32'h30, 32'h0,        2, 0,  32'hA5A5A5A5);
    run_access("rd_and_wr",  1'b1, 1'b1, 32'h40, 32'h55,       0, 1,  32'h33333333);
    run_access("last_wait",  1'b1, 1'b0, 32'h44, 32'h0,        1, TO, 32'h0BADCAFE);

    // Reset asserted while the access sits in WAIT.
    @(negedge clk);
    Mem_Read_M = 1'b1; ALU_result_M = 32'h50;
    @(negedge clk);
    Mem_Read_M = 1'b0;
    bus_if.req_ready = 1'b1;
    @(negedge clk);
    bus_if.req_ready = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("rst_wait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 check_all_zero("after_rst");
    $display("txn rst_wait reset applied during WAIT and released");
    run_access("post_rst", 1'b1, 1'b0, 32'h60, 32'h0, 1, 2, 32'h76543210);

    for (int i = 0; i < 40; i++) begin
      logic        rd, wr;
      logic [31:0] addr;
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_access($sformatf("rand%0d", i), rd, wr, addr, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 6), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
